// File: rtl/note_sequencer.sv
// Table-driven melody player: walks {duration, note} entries of the selected song
// from a synchronous ROM, holding each note for a number of tempo steps.
module note_sequencer #(
    parameter int NOTE_W     = 8,
    parameter int DUR_W      = 4,
    parameter int IDX_W      = 6,
    parameter int SONG_W     = 2,
    parameter int STEP_TICKS = 1_000_000,
    parameter logic [(2**(SONG_W+IDX_W))*(DUR_W+NOTE_W)-1:0] ROM_IMAGE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              legato,
    input  logic [SONG_W-1:0] song_sel,
    output logic [NOTE_W-1:0] note,
    output logic              note_strobe,
    output logic              playing,
    output logic              done,
    output logic [IDX_W-1:0]  idx
);

    localparam int WORD_W = DUR_W + NOTE_W;
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int TICK_W = $clog2(STEP_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_PLAY   = 2'd3
    } state_t;

    // Word i of the image sits at bit offset i*WORD_W.
    function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        return ROM_IMAGE[addr*WORD_W +: WORD_W];
    endfunction

    state_t              state_r;
    logic [SONG_W-1:0]   song_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DUR_W-1:0]    dur_cnt_r;
    logic [DUR_W-1:0]    len_r;
    logic [TICK_W-1:0]   tick_r;
    logic [NOTE_W-1:0]   note_r;
    logic                strobe_r;
    logic                playing_r;
    logic                done_r;
    logic [WORD_W-1:0]   rom_q_r;

    logic [ADDR_W-1:0]   rom_addr_s;
    logic [DUR_W-1:0]    rom_dur_s;
    logic [NOTE_W-1:0]   rom_note_s;
    logic                step_s;
    logic                at_end_s;

    assign rom_addr_s = {song_r, idx_r};
    assign rom_dur_s  = rom_q_r[WORD_W-1:NOTE_W];
    assign rom_note_s = rom_q_r[NOTE_W-1:0];
    assign step_s     = (state_r == ST_PLAY) && !pause && (tick_r == TICK_LAST);
    // End of song: either an explicit marker, or the last step of the last slot.
    assign at_end_s   = ((state_r == ST_DECODE) && (rom_dur_s == {DUR_W{1'b0}})) ||
                        (step_s && (dur_cnt_r == DUR_W'(1)) && (idx_r == IDX_LAST));

    // Synchronous ROM read, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q_r <= {WORD_W{1'b0}};
        end else begin
            rom_q_r <= rom_word(rom_addr_s);
        end
    end

    // Playback sequencer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            song_r    <= {SONG_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            dur_cnt_r <= {DUR_W{1'b0}};
            len_r     <= {DUR_W{1'b0}};
            tick_r    <= {TICK_W{1'b0}};
            note_r    <= {NOTE_W{1'b0}};
            strobe_r  <= 1'b0;
            playing_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            if (stop) begin
                state_r   <= ST_IDLE;
                note_r    <= {NOTE_W{1'b0}};
                playing_r <= 1'b0;
                tick_r    <= {TICK_W{1'b0}};
            end else if (start) begin
                song_r    <= song_sel;
                idx_r     <= {IDX_W{1'b0}};
                tick_r    <= {TICK_W{1'b0}};
                playing_r <= 1'b1;
                state_r   <= ST_FETCH;
            end else if (at_end_s) begin
                if (loop_en) begin
                    idx_r   <= {IDX_W{1'b0}};
                    state_r <= ST_FETCH;
                end else begin
                    note_r    <= {NOTE_W{1'b0}};
                    done_r    <= 1'b1;
                    playing_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        note_r    <= {NOTE_W{1'b0}};
                        playing_r <= 1'b0;
                    end
                    ST_FETCH: begin
                        state_r <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        note_r    <= rom_note_s;
                        dur_cnt_r <= rom_dur_s;
                        len_r     <= rom_dur_s;
                        tick_r    <= {TICK_W{1'b0}};
                        strobe_r  <= 1'b1;
                        state_r   <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (!pause) begin
                            if (tick_r == TICK_LAST) begin
                                tick_r <= {TICK_W{1'b0}};
                                if (dur_cnt_r > DUR_W'(1)) begin
                                    dur_cnt_r <= dur_cnt_r - DUR_W'(1);
                                    // Entering the final step: silence it unless legato.
                                    if ((dur_cnt_r == DUR_W'(2)) && !legato && (len_r >= DUR_W'(2))) begin
                                        note_r <= {NOTE_W{1'b0}};
                                    end else begin
                                        note_r <= note_r;
                                    end
                                end else begin
                                    idx_r   <= idx_r + IDX_W'(1);
                                    state_r <= ST_FETCH;
                                end
                            end else begin
                                tick_r <= tick_r + TICK_W'(1);
                            end
                        end else begin
                            tick_r <= tick_r;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign note        = note_r;
    assign note_strobe = strobe_r;
    assign playing     = playing_r;
    assign done        = done_r;
    assign idx         = idx_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expands song tables into an expected per-cycle
// timeline and compares every output cycle by cycle.
module tb_note_sequencer;

    localparam int NOTE_W  = 8;
    localparam int DUR_W   = 4;
    localparam int IDX_W   = 3;
    localparam int SONG_W  = 1;
    localparam int TICKS   = 4;
    localparam int IDX_MAX = 7;
    localparam logic [191:0] ROM_IMG = {
        12'h108, 12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h11E, 12'h21B};

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic              legato;
    logic [SONG_W-1:0] song_sel;
    logic [NOTE_W-1:0] note;
    logic              note_strobe;
    logic              playing;
    logic              done;
    logic [IDX_W-1:0]  idx;

    note_sequencer #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W),
        .STEP_TICKS(TICKS), .ROM_IMAGE(ROM_IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .legato(legato), .song_sel(song_sel),
        .note(note), .note_strobe(note_strobe), .playing(playing),
        .done(done), .idx(idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seen27 = 0;
    int snote [2][8];
    int sdur  [2][8];
    int q_note[$], q_strb[$], q_done[$], q_play[$], q_idx[$], q_frz[$];

    task automatic check(input string tag, input logic [31:0] obs, input int exp_v);
        checks++;
        assert (obs === 32'(exp_v)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int n, input int s, input int d, input int p, input int i, input int f);
        q_note.push_back(n); q_strb.push_back(s); q_done.push_back(d);
        q_play.push_back(p); q_idx.push_back(i);  q_frz.push_back(f);
    endtask

    // Expected outputs from the cycle after the accepted start edge onwards.
    task automatic gen_trace(input int song, input int leg, input int lp, input int max_len, input int prev);
        int i, cur, v, d;
        bit fin;
        q_note.delete(); q_strb.delete(); q_done.delete();
        q_play.delete(); q_idx.delete();  q_frz.delete();
        cur = prev;
        repeat (2) push(cur, 0, 0, 1, 0, 0);
        i = 0;
        fin = 1'b0;
        while (!fin && q_note.size() < max_len) begin
            d = sdur[song][i];
            for (int s = 0; s < d; s++) begin
                v = (leg == 0 && d >= 2 && s == d - 1) ? 0 : snote[song][i];
                for (int t = 0; t < TICKS; t++) push(v, (s == 0 && t == 0) ? 1 : 0, 0, 1, i, 1);
                cur = v;
            end
            if (i == IDX_MAX) begin
                if (lp != 0) begin repeat (2) push(cur, 0, 0, 1, 0, 0); i = 0; end
                else begin push(0, 0, 1, 0, i, 0); fin = 1'b1; end
            end else begin
                repeat (2) push(cur, 0, 0, 1, i + 1, 0);
                if (sdur[song][i+1] == 0) begin
                    if (lp != 0) begin repeat (2) push(cur, 0, 0, 1, 0, 0); i = 0; end
                    else begin push(0, 0, 1, 0, i + 1, 0); fin = 1'b1; end
                end else begin
                    i++;
                end
            end
        end
        if (fin) repeat (3) push(0, 0, 0, 0, q_idx[q_idx.size()-1], 0);
    endtask

    // A pause starting while playing repeats the last visible cycle len times.
    task automatic insert_pause(input int p, input int len);
        for (int k = 0; k < len; k++) begin
            q_note.insert(p, q_note[p-1]); q_strb.insert(p, 0); q_done.insert(p, 0);
            q_play.insert(p, q_play[p-1]); q_idx.insert(p, q_idx[p-1]); q_frz.insert(p, 1);
        end
    endtask

    // Caller sits at a negedge; after return the first trace cycle is visible.
    task automatic launch(input int s);
        song_sel = SONG_W'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        song_sel = SONG_W'(s ^ 1);
    endtask

    task automatic run_trace(input string tag, input int n, input int pause_at, input int pause_len);
        int lim;
        lim = (n < 0 || n > q_note.size()) ? q_note.size() : n;
        for (int j = 0; j < lim; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("%s[%0d].note", tag, j),    note,        q_note[j]);
            check($sformatf("%s[%0d].strobe", tag, j),  note_strobe, q_strb[j]);
            check($sformatf("%s[%0d].done", tag, j),    done,        q_done[j]);
            check($sformatf("%s[%0d].playing", tag, j), playing,     q_play[j]);
            check($sformatf("%s[%0d].idx", tag, j),     idx,         q_idx[j]);
            if (note === 8'd27) seen27++;
            if (pause_at > 0 && j == pause_at - 1) pause = 1'b1;
            if (pause_at > 0 && j == pause_at + pause_len - 1) pause = 1'b0;
        end
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check({tag, ".note"}, note, 0);
        check({tag, ".playing"}, playing, 0);
        check({tag, ".done"}, done, 0);
    endtask

    initial begin
        int p, plen, sng, leg, lp;
        for (int s = 0; s < 2; s++)
            for (int e = 0; e < 8; e++) begin snote[s][e] = 0; sdur[s][e] = 0; end
        snote[0][0] = 27; sdur[0][0] = 2;
        snote[0][1] = 30; sdur[0][1] = 1;
        for (int e = 0; e < 8; e++) begin snote[1][e] = e + 1; sdur[1][e] = 1; end

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        loop_en = 1'b0; legato = 1'b1; song_sel = 1'b0;
        #1;
        check("reset.note", note, 0);
        check("reset.playing", playing, 0);
        check("reset.done", done, 0);
        check("reset.strobe", note_strobe, 0);
        check("reset.idx", idx, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic legato playback of song 0
        legato = 1'b1; loop_en = 1'b0;
        gen_trace(0, 1, 0, 1000, 0);
        launch(0);
        run_trace("basic", -1, 0, 0);

        // Articulation rest on the two-step note
        @(negedge clk);
        legato = 1'b0;
        gen_trace(0, 0, 0, 1000, 0);
        launch(0);
        run_trace("artic", -1, 0, 0);

        // Loop: no done, sequence repeats
        @(negedge clk);
        legato = 1'b1; loop_en = 1'b1;
        gen_trace(0, 1, 1, 50, 0);
        launch(0);
        run_trace("loop", -1, 0, 0);
        loop_en = 1'b0;
        do_stop("loop_stop");

        // Implicit end on the last slot of song 1
        @(negedge clk);
        gen_trace(1, 1, 0, 1000, 0);
        launch(1);
        run_trace("implicit", -1, 0, 0);

        // Pause 10 cycles in the middle of note 27, then stop+start together
        @(negedge clk);
        gen_trace(0, 1, 0, 1000, 0);
        insert_pause(6, 10);
        seen27 = 0;
        launch(0);
        run_trace("pause", 24, 6, 10);
        check("pause.len27", seen27, 20);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        check("stopstart.note", note, 0);
        check("stopstart.playing", playing, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stopstart.idle[%0d].done", k), done, 0);
            check($sformatf("stopstart.idle[%0d].playing", k), playing, 0);
        end

        // Restart while playing: note holds until the new entry is decoded
        gen_trace(0, 1, 0, 1000, 0);
        launch(0);
        run_trace("pre_restart", 8, 0, 0);
        gen_trace(1, 1, 0, 1000, 27);
        launch(1);
        run_trace("restart", -1, 0, 0);

        // Asynchronous reset in the middle of song 1
        @(negedge clk);
        gen_trace(1, 1, 0, 1000, 0);
        launch(1);
        run_trace("pre_reset", 20, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.note", note, 0);
        check("async_rst.playing", playing, 0);
        check("async_rst.idx", idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gen_trace(1, 1, 0, 1000, 0);
        launch(1);
        run_trace("post_reset", -1, 0, 0);

        // Randomised song/legato/loop/pause combinations
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            sng = $urandom_range(1, 0);
            leg = $urandom_range(1, 0);
            lp  = $urandom_range(1, 0);
            legato  = leg[0];
            loop_en = lp[0];
            gen_trace(sng, leg, lp, 70, 0);
            p = 0;
            plen = $urandom_range(6, 1);
            if ($urandom_range(1, 0) == 1) begin
                for (int c = $urandom_range(30, 3); c < q_note.size(); c++)
                    if (p == 0 && q_frz[c-1] == 1) p = c;
                if (p > 0) insert_pause(p, plen);
            end
            launch(sng);
            run_trace($sformatf("rand%0d", r), -1, p, plen);
            loop_en = 1'b0;
            do_stop($sformatf("rand%0d_stop", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
